// File: rtl/alu_iter_shifter.sv
// alu_iter_shifter: multi-cycle shift/rotate unit, one bit per clock.
// Supports SHL/SHR/SAR/ROL/ROR/RCL/RCR on a full-width or byte-wide operand
// and produces x86-style flags under a start/busy/done handshake.
module alu_iter_shifter #(
    parameter int WIDTH      = 16,
    parameter int COUNT_BITS = 8,
    parameter int MASK_COUNT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic                  narrow,
    input  logic [WIDTH-1:0]      a,
    input  logic [COUNT_BITS-1:0] count,
    input  logic [15:0]           flags_in,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      out,
    output logic [15:0]           flags_out
);

    localparam logic [2:0] OP_SHL = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd1;
    localparam logic [2:0] OP_SAR = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;
    localparam logic [2:0] OP_RCL = 3'd5;
    localparam logic [2:0] OP_RCR = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    localparam logic [COUNT_BITS-1:0] ONE = COUNT_BITS'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0]      work;
    logic [2:0]            op_q;
    logic                  narrow_q;
    logic [15:0]           flags_q;
    logic                  carry_q;
    logic [COUNT_BITS-1:0] remaining;

    logic [COUNT_BITS-1:0] eff_count;
    logic                  passthru;
    logic                  accept;

    logic [WIDTH-1:0]      step_val;
    logic                  step_cf;
    logic                  step_of;
    logic [15:0]           step_flags;
    logic                  msb_old;
    logic                  msb_new;
    logic                  msb2_new;
    logic                  in_bit;
    logic                  is_left;
    logic                  is_shift;
    logic                  zero_res;

    // Effective count (optionally masked to 5 bits) and the zero-work shortcut
    always_comb begin
        eff_count = count;
        if (MASK_COUNT != 0) begin
            eff_count = COUNT_BITS'(count[4:0]);
        end
        passthru = (eff_count == '0) || (op == OP_RSV);
        accept   = start && (state != SHIFT);
    end

    // One 1-bit step of the latched operation plus the flags it would produce
    always_comb begin
        step_val   = work;
        step_cf    = carry_q;
        step_of    = 1'b0;
        in_bit     = 1'b0;
        msb_old    = narrow_q ? work[7] : work[WIDTH-1];
        is_left    = (op_q == OP_SHL) || (op_q == OP_ROL) || (op_q == OP_RCL);
        is_shift   = (op_q == OP_SHL) || (op_q == OP_SHR) || (op_q == OP_SAR);
        if (is_left) begin
            if (op_q == OP_ROL) in_bit = msb_old;
            if (op_q == OP_RCL) in_bit = carry_q;
            step_cf = msb_old;
            if (narrow_q) step_val[7:0] = {work[6:0], in_bit};
            else          step_val      = {work[WIDTH-2:0], in_bit};
        end else begin
            if (op_q == OP_SAR) in_bit = msb_old;
            if (op_q == OP_ROR) in_bit = work[0];
            if (op_q == OP_RCR) in_bit = carry_q;
            step_cf = work[0];
            if (narrow_q) step_val[7:0] = {in_bit, work[7:1]};
            else          step_val      = {in_bit, work[WIDTH-1:1]};
        end
        msb_new  = narrow_q ? step_val[7] : step_val[WIDTH-1];
        msb2_new = narrow_q ? step_val[6] : step_val[WIDTH-2];
        zero_res = narrow_q ? (step_val[7:0] == 8'h00) : (step_val == '0);
        case (op_q)
            OP_SHL, OP_ROL, OP_RCL: step_of = msb_new ^ step_cf;
            OP_SHR:                 step_of = msb_old;
            OP_ROR, OP_RCR:         step_of = msb_new ^ msb2_new;
            default:                step_of = 1'b0;
        endcase
        step_flags     = flags_q;
        step_flags[0]  = step_cf;
        step_flags[11] = step_of;
        if (is_shift) begin
            step_flags[2] = ~^step_val[7:0];
            step_flags[4] = 1'b0;
            step_flags[6] = zero_res;
            step_flags[7] = msb_new;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                done       = (state == DONE);
                next_state = IDLE;
                if (start) next_state = passthru ? DONE : SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (remaining == ONE) next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand latch, stepping datapath and registered results
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            work      <= '0;
            op_q      <= '0;
            narrow_q  <= 1'b0;
            flags_q   <= '0;
            carry_q   <= 1'b0;
            remaining <= '0;
            out       <= '0;
            flags_out <= '0;
        end else if (accept) begin
            work      <= a;
            op_q      <= op;
            narrow_q  <= narrow;
            flags_q   <= flags_in;
            carry_q   <= flags_in[0];
            remaining <= eff_count;
            if (passthru) begin
                out       <= a;
                flags_out <= flags_in;
            end
        end else if (state == SHIFT) begin
            work      <= step_val;
            carry_q   <= step_cf;
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
                out       <= step_val;
                flags_out <= step_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_iter_shifter.sv
// tb_alu_iter_shifter: directed-vector bench for alu_iter_shifter (WIDTH=16,
// COUNT_BITS=8, MASK_COUNT=1) with hand-computed results, flags and latency.
module tb_alu_iter_shifter;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic        narrow;
    logic [15:0] a;
    logic [7:0]  count;
    logic [15:0] flags_in;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic [15:0] flags_out;

    int n_compared;
    int n_mismatched;
    int done_cyc;
    int busy_cyc;
    int done_seen;

    alu_iter_shifter #(
        .WIDTH(16),
        .COUNT_BITS(8),
        .MASK_COUNT(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .op(op),
        .narrow(narrow),
        .a(a),
        .count(count),
        .flags_in(flags_in),
        .busy(busy),
        .done(done),
        .out(out),
        .flags_out(flags_out)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one operation (start high in cycle 0) and measure done cycle and busy cycles
    task automatic applyStimulus(input logic [2:0] op_v, input logic nar, input logic [15:0] a_v,
                                 input logic [7:0] cnt, input logic [15:0] fl,
                                 output int d_cyc, output int b_cyc);
        op       = op_v;
        narrow   = nar;
        a        = a_v;
        count    = cnt;
        flags_in = fl;
        start    = 1'b1;
        d_cyc    = -1;
        b_cyc    = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (busy) b_cyc++;
            if (done) begin
                d_cyc = c;
                break;
            end
        end
    endtask

    // Directed sequence
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        op       = 3'd0;
        narrow   = 1'b0;
        a        = 16'h0000;
        count    = 8'h00;
        flags_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset out", {16'd0, out}, 32'h0);
        checkOutput("reset flags", {16'd0, flags_out}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // SHL 0x8001 by 1
        applyStimulus(3'd0, 1'b0, 16'h8001, 8'd1, 16'h0000, done_cyc, busy_cyc);
        checkOutput("shl out", {16'd0, out}, 32'h0002);
        checkOutput("shl flags", {16'd0, flags_out}, 32'h0801);
        checkOutput("shl done cycle", done_cyc, 32'd2);
        checkOutput("shl busy cycles", busy_cyc, 32'd1);

        // RCR narrow by 2 with CF=1, ZF/PF preset
        applyStimulus(3'd6, 1'b1, 16'h1201, 8'd2, 16'h0045, done_cyc, busy_cyc);
        checkOutput("rcr out", {16'd0, out}, 32'h12C0);
        checkOutput("rcr flags", {16'd0, flags_out}, 32'h0044);
        checkOutput("rcr done cycle", done_cyc, 32'd3);

        // SAR with masked count 0x21 -> 1
        applyStimulus(3'd2, 1'b0, 16'h8000, 8'h21, 16'h0000, done_cyc, busy_cyc);
        checkOutput("sar out", {16'd0, out}, 32'hC000);
        checkOutput("sar flags", {16'd0, flags_out}, 32'h0084);
        checkOutput("sar done cycle", done_cyc, 32'd2);

        // SAR with masked count 0x20 -> 0, pass-through
        applyStimulus(3'd2, 1'b0, 16'h8000, 8'h20, 16'h0A55, done_cyc, busy_cyc);
        checkOutput("sar0 out", {16'd0, out}, 32'h8000);
        checkOutput("sar0 flags", {16'd0, flags_out}, 32'h0A55);
        checkOutput("sar0 done cycle", done_cyc, 32'd1);

        // ROL by 17
        applyStimulus(3'd3, 1'b0, 16'h8000, 8'd17, 16'h0000, done_cyc, busy_cyc);
        checkOutput("rol out", {16'd0, out}, 32'h0001);
        checkOutput("rol flags", {16'd0, flags_out}, 32'h0801);
        checkOutput("rol done cycle", done_cyc, 32'd18);
        checkOutput("rol busy cycles", busy_cyc, 32'd17);

        // SHR to zero
        applyStimulus(3'd1, 1'b0, 16'h0001, 8'd1, 16'h0000, done_cyc, busy_cyc);
        checkOutput("shr out", {16'd0, out}, 32'h0000);
        checkOutput("shr flags", {16'd0, flags_out}, 32'h0045);

        // RCL full width by 2 with CF=1
        applyStimulus(3'd5, 1'b0, 16'h4000, 8'd2, 16'h0001, done_cyc, busy_cyc);
        checkOutput("rcl out", {16'd0, out}, 32'h0002);
        checkOutput("rcl flags", {16'd0, flags_out}, 32'h0801);

        // Reserved op passes operand and flags through
        applyStimulus(3'd7, 1'b0, 16'h1234, 8'd3, 16'h0001, done_cyc, busy_cyc);
        checkOutput("rsv out", {16'd0, out}, 32'h1234);
        checkOutput("rsv flags", {16'd0, flags_out}, 32'h0001);
        checkOutput("rsv done cycle", done_cyc, 32'd1);

        // Start while busy is ignored
        op = 3'd0; narrow = 1'b0; a = 16'h0003; count = 8'd5; flags_in = 16'h0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        op = 3'd1; a = 16'hFFFF; count = 8'd1; flags_in = 16'h0FFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cyc = -1;
        for (int c = 4; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        checkOutput("ignore done cycle", done_cyc, 32'd6);
        checkOutput("ignore out", {16'd0, out}, 32'h0060);
        checkOutput("ignore flags", {16'd0, flags_out}, 32'h0004);

        // Reset in the middle of an operation aborts it without done
        op = 3'd0; a = 16'h0003; count = 8'd5; flags_in = 16'h0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("pre-reset busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort out", {16'd0, out}, 32'h0);
        checkOutput("abort flags", {16'd0, flags_out}, 32'h0);
        done_seen = (done === 1'b1) ? 1 : 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        checkOutput("abort no done", done_seen, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/alu_iter_shifter.md
# alu_iter_shifter

Multi-cycle, width-parametrised shift/rotate unit for the execution datapath. It performs one bit of SHL/SHR/SAR/ROL/ROR/RCL/RCR per clock, for an arbitrary count, and produces x86-style flags. A full-width or byte-wide operand is processed under a start/busy/done handshake. It offloads count-driven shifts from the single-cycle ALU so the microcode no longer loops one bit at a time.

## Interface
- WIDTH, 16, operand width; multiple of 8, at least 8
- COUNT_BITS, 8, width of the count input
- MASK_COUNT, 1, when 1 the effective count is count[4:0] (80186 behaviour); when 0 the full count is used
- clk  in  1  clock
- reset_n  in  1  synchronous reset, active low
- start  in  1  request; accepted only when busy=0
- op  in  3  0 SHL, 1 SHR, 2 SAR, 3 ROL, 4 ROR, 5 RCL, 6 RCR, 7 reserved
- narrow  in  1  1: operate on a[7:0] only
- a  in  WIDTH  operand
- count  in  COUNT_BITS  shift count
- flags_in  in  16  flags word; CF=0, PF=2, AF=4, ZF=6, SF=7, OF=11
- busy  out  1  high while stepping
- done  out  1  one-cycle pulse; out/flags_out valid
- out  out  WIDTH  result; held until the next accepted start
- flags_out  out  16  resulting flags; held with out

## Operation
- States: IDLE, SHIFT, DONE. busy = (state==SHIFT). done = (state==DONE).
- When start is sampled with busy=0 (in IDLE or DONE), the unit latches a, op, narrow and flags_in, and computes n = MASK_COUNT ? count[4:0] : count.
  - If n==0 or op==7, next state is DONE. out=a and flags_out=flags_in.
  - Otherwise, next state is SHIFT with remaining=n.
- SHIFT: on each edge, perform one 1-bit step on the working value and decrement remaining. The edge that performs the final step (remaining==1) moves the state to DONE.
- DONE lasts one cycle, then the state goes to IDLE. A start in the DONE cycle is accepted as if in IDLE.
- start while busy=1 is ignored; the operation in flight is unaffected.
- Step semantics:
  - Operating MSB = bit 7 if narrow, else bit WIDTH-1.
  - In narrow mode out[WIDTH-1:8] = a[WIDTH-1:8] unchanged.
  - SHL: shifts in 0 at the LSB. SHR: shifts in 0 at the MSB. SAR: replicates the MSB.
  - ROL/ROR: the bit leaving the operand re-enters at the other end.
  - RCL/RCR: rotate through CF; the old CF enters and the bit leaving becomes the new CF.
  - CF = the last bit shifted or rotated out, for all ops.
- OF comes from the last step only, for any n≥1:
  - SHL/ROL/RCL: MSB(result) xor CF.
  - SHR: MSB of the value before the last step.
  - SAR: 0.
  - ROR/RCR: MSB(result) xor (MSB-1)(result).
- Shifts (SHL/SHR/SAR) also update:
  - ZF = result==0, over the operating width.
  - SF = MSB(result).
  - PF = even parity of result[7:0].
  - AF = 0.
- Rotates modify only CF and OF.
- All other flag bits pass through from the latched flags_in.

## Timing
- Reset (reset_n=0 at an edge): state=IDLE, busy=0, done=0, out=0, flags_out=0. This aborts any operation in progress, and no done is produced for it.
- Latency: with start high in cycle 0, done is high in cycle n+1. For n=0 or op 7 that is cycle 1.
- busy is high in cycles 1..n and low in the done cycle.
- Throughput: a new start can be issued in the done cycle. Back-to-back operations therefore take n+1 cycles each.
- out and flags_out are registered. They change only on the edge entering DONE, and on reset.

## Test plan
- WIDTH=16, SHL, a=0x8001, count=1, flags_in=0 -> out=0x0002, CF=1, OF=1, ZF=0, SF=0, PF=0; done in cycle 2, busy high in cycle 1 only.
- RCR, narrow=1, a=0x1201, count=2, CF=1 -> out=0x12C0, CF=0, OF=0, ZF/SF/PF unchanged from flags_in; done in cycle 3.
- MASK_COUNT=1, SAR, a=0x8000:
  - count=0x21 -> out=0xC000, CF=0, OF=0, SF=1, done in cycle 2.
  - count=0x20 -> out=0x8000, flags_out=flags_in, done in cycle 1.
- ROL, a=0x8000, count=17 -> out=0x0001, CF=1, OF=1; done in cycle 18.
- SHR, a=0x0001, count=1, flags_in=0x0000 -> out=0, CF=1, ZF=1, PF=1, OF=0, SF=0.
- Start SHL count=5. Pulse start with different operands in cycle 2; the second start is ignored and the first result is produced in cycle 6. Then, in a new SHL count=5, drop reset_n in cycle 3 -> busy=0, out=0, flags_out=0 from cycle 4, and no done.
